div_unit: RTL
=============

Name: div_unit

Overview:
Multi-cycle signed integer divider for the processor datapath; the inverse-operation companion to the multiply unit and feeding the same hi/lo registers.
Computes A / B by restoring division, one quotient bit per clock, on operand magnitudes, with a final sign-fix cycle.
Quotient goes to lo and remainder to hi, following the MIPS DIV convention.
The control unit starts it with a one-cycle div_in pulse and stalls until div_out.

Parameters:
WIDTH, 32, operand/result width; hi/lo width; iteration count.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
A  input  WIDTH  dividend, two's complement; sampled only on the start edge
B  input  WIDTH  divisor, two's complement; sampled only on the start edge
div_in  input  1  start pulse; one cycle
hi  output  WIDTH  remainder (registered)
lo  output  WIDTH  quotient (registered)
div_out  output  1  done strobe; one cycle
div_zero  output  1  divide-by-zero strobe; one cycle, coincident with div_out

Behaviour:
- Reset (synchronous, active-high) sets hi=0, lo=0, div_out=0, div_zero=0, clears internal regs and sets state IDLE. Reset wins over div_in on the same edge.
- States and transitions:
  - IDLE: wait for div_in.
  - CALC: 32 iterations.
  - FIX: sign correction and result write.
  - ZERO: divide-by-zero report.
- On start edge E0 (div_in=1):
  - latch sign_q = A[31]^B[31] and sign_r = A[31];
  - latch |A| and |B| as unsigned WIDTH values; |0x80000000| = 0x80000000;
  - clear the WIDTH-bit partial remainder; reset the counter to WIDTH.
  - Next state is ZERO if B==0, else CALC.
- CALC, each edge:
  - shift {rem, quo} left 1 with the dividend MSB entering rem;
  - trial = rem - |B| at WIDTH+1 bits;
  - if trial is non-negative, rem=trial and quo LSB=1, else quo LSB=0;
  - decrement the counter; after the 32nd iteration (edge E0+32), go to FIX.
- FIX, edge E0+33:
  - lo = sign_q ? -quo : quo;
  - hi = sign_r ? -rem : rem;
  - div_out=1; go to IDLE.
  - The quotient truncates toward zero; the remainder takes the dividend's sign.
- ZERO, edge E0+1:
  - div_out=1 and div_zero=1; hi and lo keep their previous values; go to IDLE.
- div_out and div_zero are deasserted on the edge after they assert.
- hi and lo change only on a FIX edge or on reset.
- div_in while busy (CALC/FIX/ZERO) aborts the current operation and restarts with the new operands.
  - No div_out for the aborted operation.
  - div_out is forced to 0 on the restart edge.
- Overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 through natural wrap; no flag is raised.
- Dividend 0 gives lo=0, hi=0 with full latency.

Optional Feature:
DIV_UNSIGNED_EN
- Defined:
  - adds input port div_unsigned (1 bit), sampled on the start edge;
  - when it is 1, operands are used as raw unsigned magnitudes and FIX does no negation (MIPS DIVU);
  - same latency; 0x80000000 / 0xFFFFFFFF gives lo=0, hi=0x80000000.
- Undefined: the port does not exist; the unit is signed only.

Decomposition:
- Shared package div_pkg holds:
  - state enum (IDLE, CALC, FIX, ZERO);
  - DIV_WIDTH=32;
  - DIV_ITER=32;
  - DIV_LATENCY=33 (start edge to result edge).
- One natural sub-module, div_step: a combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once; the parent holds the registers, counter and FSM.

Test Plan:
- A=100, B=7, div_in at E0: at E0+33 lo=14, hi=2, div_out=1; at E0+34 div_out=0.
- A=-7 (0xFFFFFFF9), B=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). A=7, B=-2: lo=-3, hi=1.
- A=5, B=0, with hi/lo preloaded from a prior divide: at E0+1 div_zero=1, div_out=1, hi/lo unchanged; both strobes clear at E0+2.
- A=0x80000000, B=0xFFFFFFFF: lo=0x80000000, hi=0, div_zero=0.
  - With DIV_UNSIGNED_EN and div_unsigned=1: lo=0, hi=0x80000000.
- Restart: start 100/7, pulse div_in with A=9, B=4 at E0+10:
  - no div_out before E0+43;
  - at E0+43 lo=2, hi=1.
- Reset at E0+15 during a divide: all outputs 0 at E0+16; no div_out afterward; a new 20/3 then yields lo=6, hi=2 with full latency.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle signed divider.
// Holds the FSM state encoding, the default datapath width, the iteration
// count and the start-to-result latency used by the divider and its users.
package div_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_ITER    = 32;
    localparam int DIV_LATENCY = 33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Latency: combinational; the parent registers the results every CALC cycle.
// Backpressure: none; pure function of its inputs.
// Ports: rem_i/quo_i  current partial remainder and dividend/quotient shift register
//        divisor_i    divisor magnitude
//        rem_o/quo_o  values after one shift-and-trial-subtract step
module div_step import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        // The remainder can exceed WIDTH bits after the shift when the divisor
        // is a large unsigned magnitude, so the trial runs at WIDTH+1 bits.
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed integer divider: quotient to lo, remainder to hi (MIPS DIV).
// Latency: 33 cycles start-to-result (1 for divide-by-zero); div_out pulses one cycle.
// Backpressure: none; caller stalls until div_out, a new div_in aborts and restarts.
// Ports: clock, reset (sync, active-high); A/B operands sampled on the div_in edge;
//        div_in start pulse; hi remainder, lo quotient (registered);
//        div_out done strobe; div_zero divide-by-zero strobe (with div_out).
// Build option: define DIV_UNSIGNED_EN to add the div_unsigned input (MIPS DIVU mode).
module div_unit import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             div_in,
`ifdef DIV_UNSIGNED_EN
    input  logic             div_unsigned,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_out,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;

    logic             uns;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

`ifdef DIV_UNSIGNED_EN
    assign uns = div_unsigned;
`else
    assign uns = 1'b0;
`endif

    // In unsigned mode the operands are already magnitudes and nothing is negated.
    assign a_neg = A[WIDTH-1] & ~uns;
    assign b_neg = B[WIDTH-1] & ~uns;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        done_d    = 1'b0;
        zero_d    = 1'b0;

        if (div_in) begin
            // A start in any state (re)launches; an in-flight op is dropped silently.
            quo_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            // The dividend magnitude rides in the quotient register and is
            // shifted out MSB-first as quotient bits shift in at the LSB.
            // Negating 0x80000000 wraps to itself, which is the correct magnitude.
            quo_d     = a_neg ? -A : A;
            dvsr_d    = b_neg ? -B : B;
            rem_d     = '0;
            cnt_d     = CW'(WIDTH);
            state_d   = (B == '0) ? ZERO : CALC;
        end else begin
            case (state_q)
                IDLE: begin
                end
                CALC: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    lo_d    = quo_neg_q ? -quo_q : quo_q;
                    hi_d    = rem_neg_q ? -rem_q : rem_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                ZERO: begin
                    // hi/lo deliberately untouched.
                    done_d  = 1'b1;
                    zero_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            done_q    <= done_d;
            zero_q    <= zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_out  = done_q;
    assign div_zero = zero_q;

endmodule
